// File: rtl/orientation_pkg.sv
// Shared types and constants for the orientation SPI receiver and the face renderer.
package orientation_pkg;

  localparam int unsigned WORD_W_DEF = 32;
  localparam int unsigned SQUARES    = 9;
  localparam int unsigned SQ_W       = 3;

  // Square color codes, shared with the renderer's color conversion
  localparam logic [SQ_W-1:0] COLOR_RED    = 3'b000;
  localparam logic [SQ_W-1:0] COLOR_ORANGE = 3'b001;
  localparam logic [SQ_W-1:0] COLOR_YELLOW = 3'b010;
  localparam logic [SQ_W-1:0] COLOR_GREEN  = 3'b011;
  localparam logic [SQ_W-1:0] COLOR_BLUE   = 3'b100;
  localparam logic [SQ_W-1:0] COLOR_PURPLE = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    COMMIT = 3'd2,
    RENDER = 3'd3,
    DONE   = 3'd4
  } state_e;

  // True when every square field holds a defined color code
  function automatic logic squares_ok(input logic [SQUARES*SQ_W-1:0] f);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < int'(SQUARES); k++) begin
      if (f[k*SQ_W +: SQ_W] > COLOR_PURPLE) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/orientation_rx_sync_edge.sv
// Multi-stage pin synchronizer with registered rise/fall pulses against a delayed copy.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   q_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
      q_d    <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      q_d    <= sync_r[SYNC_STAGES-1];
      rise   <= sync_r[SYNC_STAGES-1] & ~q_d;
      fall   <= ~sync_r[SYNC_STAGES-1] & q_d;
    end
  end

  assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/orientation_rx.sv
// Oversampled SPI receiver for the cube orientation word with renderer handshake.
// Optional build macro ORIENT_CHECK_EN adds color-field validation at commit.
module orientation_rx
  import orientation_pkg::*;
#(
  parameter int unsigned WORD_W      = WORD_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              sdi,
  input  logic              load,
  input  logic              frame_done,
  output logic [WORD_W-1:0] orientation,
  output logic              orient_valid,
  output logic              done,
  output logic              frame_err
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_W + 1);

  logic sdi_s;
  logic sck_rise, load_rise, load_fall;
  logic unused_sck_q, unused_sck_fall, unused_load_q, unused_sdi_rise, unused_sdi_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
    .clk(clk), .reset_n(reset_n), .din(sck),
    .q(unused_sck_q), .rise(sck_rise), .fall(unused_sck_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load (
    .clk(clk), .reset_n(reset_n), .din(load),
    .q(unused_load_q), .rise(load_rise), .fall(load_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sdi (
    .clk(clk), .reset_n(reset_n), .din(sdi),
    .q(sdi_s), .rise(unused_sdi_rise), .fall(unused_sdi_fall)
  );

  state_e            state;
  logic [WORD_W-1:0] sh, sh_nxt_c;
  logic [CNT_W-1:0]  bcnt, bcnt_nxt_c;
  logic              frame_ok_c;

  // Shift applied ahead of the commit decision so a coincident sck rise is counted
  always_comb begin
    sh_nxt_c   = sh;
    bcnt_nxt_c = bcnt;
    if (state == SHIFT && sck_rise) begin
      sh_nxt_c = {sh[WORD_W-2:0], sdi_s};
      if (bcnt != CNT_SAT) bcnt_nxt_c = bcnt + CNT_W'(1);
    end
  end

`ifdef ORIENT_CHECK_EN
  always_comb begin
    frame_ok_c = (bcnt_nxt_c == CNT_FULL)
              && (sh_nxt_c[WORD_W-1:SQUARES*SQ_W] == '0)
              && squares_ok(sh_nxt_c[SQUARES*SQ_W-1:0]);
  end
`else
  always_comb begin
    frame_ok_c = (bcnt_nxt_c == CNT_FULL);
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      sh           <= '0;
      bcnt         <= '0;
      orientation  <= '0;
      orient_valid <= 1'b0;
      done         <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      orient_valid <= 1'b0;
      sh           <= sh_nxt_c;
      bcnt         <= bcnt_nxt_c;
      if (load_rise) begin
        // A new frame pre-empts whatever the block was doing
        state <= SHIFT;
        bcnt  <= '0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          SHIFT: begin
            if (load_fall) begin
              state <= COMMIT;
              if (frame_ok_c) begin
                orientation  <= sh_nxt_c;
                orient_valid <= 1'b1;
                frame_err    <= 1'b0;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end
          COMMIT: state <= orient_valid ? RENDER : IDLE;
          RENDER: begin
            if (frame_done) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE:    state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_orientation_rx.sv
// Self-checking bench for orientation_rx: vector table plus commit scoreboard.
module tb_orientation_rx;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int          LAT         = SYNC_STAGES + 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              sck = 1'b0;
  logic              sdi = 1'b0;
  logic              load = 1'b0;
  logic              frame_done = 1'b0;
  logic [WORD_W-1:0] orientation;
  logic              orient_valid;
  logic              done;
  logic              frame_err;

  orientation_rx #(.WORD_W(WORD_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .load(load),
    .frame_done(frame_done), .orientation(orientation),
    .orient_valid(orient_valid), .done(done), .frame_err(frame_err)
  );

  always #12 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          fall_cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_orient = '0;
  logic        exp_err = 1'b0;
  logic        prev_v = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_ok(input logic [31:0] w, input int nbits);
    logic ok;
    ok = (nbits == 32);
`ifdef ORIENT_CHECK_EN
    if (w[31:27] != 5'd0) ok = 1'b0;
    for (int k = 0; k < 9; k++) if (w[3*k +: 3] > 3'd5) ok = 1'b0;
`else
    if (w === 32'hx) ok = 1'b0;
`endif
    return ok;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sck_bit(input logic b);
    sdi = b;
    cycles(4);
    sck = 1'b1;
    cycles(4);
    sck = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] data, input int nbits, input bit stray);
    cycles(1);
    load = 1'b1;
    cycles(LAT);
    check("done_drop_on_load", 64'(done), 64'd0);
    cycles(2);
    for (int i = nbits - 1; i >= 0; i--) begin
      sck_bit(data[i]);
      if (stray && i == nbits / 2) begin
        frame_done = 1'b1;
        cycles(1);
        frame_done = 1'b0;
        cycles(1);
        check("stray_frame_done", 64'(done), 64'd0);
      end
    end
    sdi = 1'b0;
    cycles(4);
    load = 1'b0;
    fall_cyc = cyc;
    if (model_ok(data[31:0], nbits)) begin
      exp_q.push_back(data[31:0]);
      exp_orient = data[31:0];
      exp_err = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  // Scoreboard: every orient_valid pulse must match a queued commit at the fixed latency
  always @(negedge clk) begin
    if (reset_n) begin
      if (orient_valid) begin
        if (prev_v) begin
          n_vec++;
          n_bad++;
          $display("FAIL ov_consecutive: orient_valid high two cycles in a row");
        end
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL ov_unexpected: got pulse with orientation %0h, expected none", orientation);
        end else begin
          check("commit_orientation", 64'(orientation), 64'(exp_q.pop_front()));
          check("ov_latency", 64'(cyc - fall_cyc), 64'(LAT));
        end
      end
      prev_v = orient_valid;
    end else begin
      prev_v = 1'b0;
    end
  end

  typedef struct {
    logic [39:0] data;
    int          nbits;
    bit          fdone;
    bit          stray;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{40'h00_0123_4567, 32, 1'b0, 1'b0};
    vecs[1] = '{40'h00_0492_4924, 32, 1'b1, 1'b0};
    vecs[2] = '{40'h00_1234_5678, 31, 1'b1, 1'b0};
    vecs[3] = '{40'h01_0492_4924, 33, 1'b0, 1'b0};
    vecs[4] = '{40'h00_0249_2492, 32, 1'b0, 1'b0};
    vecs[5] = '{40'h00_0492_4927, 32, 1'b1, 1'b0};
    vecs[6] = '{40'h00_0000_0000, 32, 1'b0, 1'b0};
    vecs[7] = '{40'h00_0321_0A53, 32, 1'b1, 1'b1};
    vecs[8] = '{40'h00_FFFF_FFFF, 32, 1'b1, 1'b0};

    cycles(3);
    reset_n = 1'b1;
    cycles(2);
    check("reset_orientation", 64'(orientation), 64'd0);
    check("reset_orient_valid", 64'(orient_valid), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_frame_err", 64'(frame_err), 64'd0);

    // Reset asserted in the middle of a frame discards it
    load = 1'b1;
    cycles(6);
    for (int i = 0; i < 5; i++) sck_bit(i[0]);
    reset_n = 1'b0;
    load = 1'b0;
    sck = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    cycles(LAT + 4);
    check("midreset_orientation", 64'(orientation), 64'd0);
    check("midreset_frame_err", 64'(frame_err), 64'd0);
    check("midreset_done", 64'(done), 64'd0);

    for (int v = 0; v < 9; v++) begin
      logic acc;
      acc = model_ok(vecs[v].data[31:0], vecs[v].nbits);
      send_frame(vecs[v].data, vecs[v].nbits, vecs[v].stray);
      cycles(8);
      check("orientation", 64'(orientation), 64'(exp_orient));
      check("frame_err", 64'(frame_err), 64'(exp_err));
      check("done_before_render", 64'(done), 64'd0);
      check("commits_pending", 64'(exp_q.size()), 64'd0);
      if (vecs[v].fdone) begin
        frame_done = 1'b1;
        cycles(1);
        frame_done = 1'b0;
        check("done_after_frame_done", 64'(done), 64'(acc));
        cycles(3);
        check("done_level_held", 64'(done), 64'(acc));
      end
    end

    cycles(5);
    check("final_pending", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not reach the end, expected completion");
    $fatal(1);
  end

endmodule
